// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUCtrl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       InstrDone;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, PCSrc, PCEn, InstrDone, State
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUCtrl, PCSrc, PCEn, InstrDone, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: one instruction in 2-5
// clocks, outputs decoded from the state register, enables gated by reset.
module multicycle_ctrl (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;

    logic pc_write;
    logic branch;
    logic ir_write;
    logic mem_write;
    logic reg_write;
    logic instr_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    case (bus.Opcode)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (bus.Opcode == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD: state <= MEMWB;
                EXECUTE: state <= ALUWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Unused codes 12-15 fall through to the all-zero defaults.
    always_comb begin
        bus.IorD    = 1'b0;
        bus.RegDst  = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA = 1'b0;
        bus.ALUSrcB = 2'b00;
        bus.ALUCtrl = 3'b010;
        bus.PCSrc   = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB = 2'b01;
                ir_write    = 1'b1;
                pc_write    = 1'b1;
            end
            DECODE: bus.ALUSrcB = 2'b11;
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMREAD: bus.IorD = 1'b1;
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
            end
            MEMWRITE: begin
                bus.IorD   = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                case (bus.Funct)
                    6'd34:   bus.ALUCtrl = 3'b110;
                    6'd36:   bus.ALUCtrl = 3'b000;
                    6'd37:   bus.ALUCtrl = 3'b001;
                    6'd42:   bus.ALUCtrl = 3'b111;
                    default: bus.ALUCtrl = 3'b010;
                endcase
            end
            ALUWB: begin
                bus.RegDst = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUCtrl = 3'b110;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
                instr_done  = 1'b1;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                bus.PCSrc  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset kills any pending write in the same cycle it rises.
    assign bus.PCEn      = ~reset & (pc_write | (branch & bus.Zero));
    assign bus.IRWrite   = ~reset & ir_write;
    assign bus.MemWrite  = ~reset & mem_write;
    assign bus.RegWrite  = ~reset & reg_write;
    assign bus.InstrDone = ~reset & instr_done;
    assign bus.State     = state;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle MIPS datapath. It sequences one instruction over 3–5 clocks through a shared memory, a single ALU and an instruction register. The block takes the opcode and funct held in the datapath's instruction register, plus the ALU Zero flag. It drives every mux select and write enable of the datapath and supports add, sub, and, or, slt, lw, sw, beq, addi and j.

## Interface
- No parameters.
- clk  in  1  system clock; state register updates on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- Opcode  in  6  instr[31:26] from instruction register
- Funct  in  6  instr[5:0] from instruction register
- Zero  in  1  ALU result == 0
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data-memory write enable
- IRWrite  out  1  instruction-register load enable
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = memory data register
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- ALUCtrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable
- InstrDone  out  1  high during the final state of each instruction
- State  out  4  current state encoding (debug/verification)

## Operation
- Moore FSM. All outputs are combinational from State, except:
  - ALUCtrl in EXECUTE depends on Funct.
  - PCEn = PCWrite | (Branch & Zero), where PCWrite and Branch are internal.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
  - Codes 12–15 go to FETCH next cycle with all enables low.
- Any output not listed for a state is 0; ALUCtrl defaults to 010.
- Per-state outputs:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=010, PCSrc=00, IRWrite=1, PCWrite=1
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtrl=010 (branch target into ALUOut)
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtrl=010
  - MEMREAD: IorD=1
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1
  - MEMWRITE: IorD=1, MemWrite=1, InstrDone=1
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUCtrl from Funct (32→010, 34→110, 36→000, 37→001, 42→111, other→010)
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=110, PCSrc=01, Branch=1, InstrDone=1
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUCtrl=010
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1
  - JUMP: PCSrc=10, PCWrite=1, InstrDone=1
- Transitions:
  - FETCH→DECODE
  - DECODE by Opcode: 100011 or 101011→MEMADR; 000000→EXECUTE; 000100→BRANCH; 001000→ADDIEX; 000010→JUMP; any other→FETCH (instruction is a no-op; PC already advanced)
  - MEMADR→MEMREAD if Opcode=100011, else MEMWRITE
  - MEMREAD→MEMWB; EXECUTE→ALUWB; ADDIEX→ADDIWB
  - MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP→FETCH

## Timing
- Cycles per instruction, FETCH through last state inclusive: lw 5; sw, R-type, addi 4; beq, j 3; unknown opcode 2.
- Opcode and Funct are sampled only in DECODE, MEMADR and EXECUTE. The datapath holds them stable because IRWrite is 1 only in FETCH.
- Reset asserted:
  - State=0 immediately, with no clock edge required.
  - PCEn, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0 while reset is high.
  - All other outputs take their FETCH values.
- Reset deasserted: first rising edge performs the FETCH writes (PC+4, IR load).
- Reset mid-instruction (e.g. in MEMWRITE or MEMWB): the pending write is suppressed in the same cycle reset rises; the FSM restarts at FETCH.
- BRANCH with Zero=0: PCEn=0, and the PC keeps the PC+4 value written in FETCH.
- No handshakes; memory is assumed single-cycle.

## Test plan
- Reset: assert reset mid-MEMWB, with no clock edge → State=0 and RegWrite=0 immediately. After release, first edge → State=1.
- lw: Opcode=100011 → states 0,1,2,3,4,0. MEMREAD has IorD=1. MEMWB has RegWrite=1, MemtoReg=1, RegDst=0. InstrDone high exactly 1 cycle.
- sw then addi: Opcode=101011 → 0,1,2,5,0 with MemWrite=1 only in state 5. Opcode=001000 → 0,1,9,10,0 with ALUSrcB=10 in state 9.
- R-type: Opcode=0 with Funct=34 → ALUCtrl=110 in EXECUTE; Funct=42 → 111; Funct=37 → 001; ALUWB has RegDst=1, RegWrite=1.
- beq: BRANCH with Zero=1 → PCEn=1, PCSrc=01. With Zero=0 → PCEn=0. Both return to FETCH after 3 cycles.
- j and illegal: Opcode=000010 → JUMP with PCEn=1, PCSrc=10. Opcode=111111 → DECODE→FETCH with no write enable asserted in DECODE.
